// File: rtl/hs32_mem_arbiter.sv
// hs32_mem_arbiter: fetch/execute share one memory bus; stbX->stbm 2 cycles, ackm/stlm->ackX/stlX 1 cycle.
// One latched request per side, extra strobes ignored; HS32_ARB_TIMEOUT_EN adds a WAIT timeout and tmo.
module hs32_mem_arbiter #(
  parameter int STARVE_MAX = 3
`ifdef HS32_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addrf,
  input  logic        stbf,
  output logic [31:0] dtrf,
  output logic        ackf,
  output logic        stlf,
  input  logic        flushf,
  input  logic [31:0] addre,
  input  logic [31:0] dtwe,
  input  logic        rwe,
  input  logic        stbe,
  output logic [31:0] dtre,
  output logic        acke,
  output logic        stle,
  output logic [31:0] addrm,
  output logic [31:0] dtwm,
  output logic        rwm,
  output logic        stbm,
  input  logic [31:0] dtrm,
  input  logic        ackm,
  input  logic        stlm
`ifdef HS32_ARB_TIMEOUT_EN
  , output logic      tmo
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_E = 1'b1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic          owner;
  logic          pendf, pende;
  logic [31:0]   addr_f, addr_e, dtw_e;
  logic          rw_e;
  logic          drop;
  logic [SW-1:0] starve;

  logic grant, grant_f, done, fin, fin_f, fin_e, suppress;

`ifdef HS32_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          abort;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_f   = 1'b0;
    done      = 1'b0;
`ifdef HS32_ARB_TIMEOUT_EN
    abort     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (pendf || pende) begin
          grant     = 1'b1;
          grant_f   = pendf && (!pende || (starve == SW'(STARVE_MAX)));
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ackm || stlm) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
`ifdef HS32_ARB_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef HS32_ARB_TIMEOUT_EN
  assign fin = done || abort;
`else
  assign fin = done;
`endif
  assign fin_f    = fin && (owner == OWN_F);
  assign fin_e    = fin && (owner == OWN_E);
  assign suppress = drop || flushf;

  // A strobe on the completion cycle re-arms the slot, so a requester holding stb
  // presents back-to-back requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pendf  <= 1'b0;
      addr_f <= '0;
    end else if (flushf) begin
      pendf  <= 1'b0;
    end else if (stbf && (!pendf || fin_f)) begin
      pendf  <= 1'b1;
      addr_f <= addrf;
    end else if (fin_f) begin
      pendf  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pende  <= 1'b0;
      addr_e <= '0;
      dtw_e  <= '0;
      rw_e   <= 1'b0;
    end else if (stbe && (!pende || fin_e)) begin
      pende  <= 1'b1;
      addr_e <= addre;
      dtw_e  <= dtwe;
      rw_e   <= rwe;
    end else if (fin_e) begin
      pende  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner <= OWN_F;
      addrm <= '0;
      dtwm  <= '0;
      rwm   <= 1'b0;
      stbm  <= 1'b0;
    end else begin
      stbm <= grant;
      if (grant) begin
        owner <= grant_f ? OWN_F : OWN_E;
        addrm <= grant_f ? addr_f : addr_e;
        dtwm  <= grant_f ? 32'h0 : dtw_e;
        rwm   <= grant_f ? 1'b0 : rw_e;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          starve <= '0;
    else if (!pendf)     starve <= '0;
    else if (grant)      starve <= grant_f ? '0 : starve + SW'(1);
  end

  // A flushed fetch still occupies the bus; drop only hides its response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                           drop <= 1'b0;
    else if (flushf && grant && grant_f)                  drop <= 1'b1;
    else if (fin)                                         drop <= 1'b0;
    else if (flushf && state == S_WAIT && owner == OWN_F) drop <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ackf <= 1'b0;
      stlf <= 1'b0;
      acke <= 1'b0;
      stle <= 1'b0;
      dtrf <= '0;
      dtre <= '0;
    end else begin
      ackf <= 1'b0;
      stlf <= 1'b0;
      acke <= 1'b0;
      stle <= 1'b0;
      if (done) begin
        if (owner == OWN_F) begin
          if (!suppress) begin
            if (stlm) begin
              stlf <= 1'b1;
            end else begin
              ackf <= 1'b1;
              dtrf <= dtrm;
            end
          end
        end else begin
          if (stlm) begin
            stle <= 1'b1;
          end else begin
            acke <= 1'b1;
            dtre <= dtrm;
          end
        end
      end
`ifdef HS32_ARB_TIMEOUT_EN
      if (abort) begin
        if (owner == OWN_F) stlf <= !suppress;
        else                stle <= 1'b1;
      end
`endif
    end
  end

`ifdef HS32_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
      tmo  <= 1'b0;
    end else begin
      if (state == S_WAIT && !(ackm || stlm)) tcnt <= tcnt + TW'(1);
      else                                    tcnt <= '0;
      if (abort) tmo <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Scoreboard bench for hs32_mem_arbiter: expected bus requests and responses are queued at stimulus time.
module tb_hs32_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addrf = '0, addre = '0, dtwe = '0, dtrm = '0;
  logic        stbf = 1'b0, flushf = 1'b0, rwe = 1'b0, stbe = 1'b0, ackm = 1'b0, stlm = 1'b0;
  logic [31:0] dtrf, dtre, addrm, dtwm;
  logic        ackf, stlf, acke, stle, rwm, stbm;
`ifdef HS32_ARB_TIMEOUT_EN
  logic        tmo;
`endif

  always #5 clk = ~clk;

  hs32_mem_arbiter #(
    .STARVE_MAX(3)
`ifdef HS32_ARB_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .addrf(addrf), .stbf(stbf), .dtrf(dtrf), .ackf(ackf), .stlf(stlf), .flushf(flushf),
    .addre(addre), .dtwe(dtwe), .rwe(rwe), .stbe(stbe), .dtre(dtre), .acke(acke), .stle(stle),
    .addrm(addrm), .dtwm(dtwm), .rwm(rwm), .stbm(stbm), .dtrm(dtrm), .ackm(ackm), .stlm(stlm)
`ifdef HS32_ARB_TIMEOUT_EN
    , .tmo(tmo)
`endif
  );

  typedef struct { logic [31:0] addr; logic [31:0] dtw; logic rw; } mreq_t;
  typedef struct { logic [3:0] flags; logic [31:0] dat; bit chk; } rsp_t;  // flags = {ackf,stlf,acke,stle}

  mreq_t exp_mem[$];
  rsp_t  exp_rsp[$];
  int    checks = 0;
  int    failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stbm(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (stbm === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic respond(input logic stall, input logic [31:0] d);
    if (stall) stlm = 1'b1;
    else       ackm = 1'b1;
    dtrm = d;
    step();
    ackm = 1'b0;
    stlm = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    step();
    step();
    checks++;
    if ({ackf, stlf, acke, stle, stbm, rwm} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl: got %b, expected 000000", {ackf, stlf, acke, stle, stbm, rwm});
    end
    checks++;
    if ({addrm, dtwm, dtrf, dtre} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data: got addrm=%h dtwm=%h dtrf=%h dtre=%h, expected all 0", addrm, dtwm, dtrf, dtre);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    mreq_t m; rsp_t r; int n;
    addrf = 32'h100; stbf = 1'b1;
    exp_mem.push_back('{32'h100, 32'h0, 1'b0});
    exp_rsp.push_back('{4'b1000, 32'hDEADBEEF, 1'b1});
    step();
    stbf = 1'b0;
    wait_stbm(6, n);
    m = exp_mem.pop_front(); checks++;
    if (n != 1 || addrm !== m.addr || rwm !== m.rw) begin
      failures++;
      $display("FAIL single_req: lat=%0d addrm=%h rwm=%b, expected lat=1 addrm=%h rwm=%b", n, addrm, rwm, m.addr, m.rw);
    end
    step();
    checks++;
    if (stbm !== 1'b0 || addrm !== 32'h100) begin
      failures++;
      $display("FAIL single_pulse: stbm=%b addrm=%h, expected stbm=0 addrm=00000100", stbm, addrm);
    end
    respond(1'b0, 32'hDEADBEEF);
    r = exp_rsp.pop_front(); checks++;
    if ({ackf, stlf, acke, stle} !== r.flags || (r.chk && r.flags[3] && dtrf !== r.dat)) begin
      failures++;
      $display("FAIL single_rsp: flags=%b dtrf=%h, expected flags=%b dtrf=%h", {ackf, stlf, acke, stle}, dtrf, r.flags, r.dat);
    end
    step();
    checks++;
    if (ackf !== 1'b0 || dtrf !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_hold: ackf=%b dtrf=%h, expected ackf=0 dtrf=deadbeef", ackf, dtrf);
    end
  endtask

  task automatic test_priority();
    mreq_t m; rsp_t r; int n;
    addrf = 32'h200; stbf = 1'b1;
    addre = 32'h3000; dtwe = 32'h55; rwe = 1'b1; stbe = 1'b1;
    exp_mem.push_back('{32'h3000, 32'h55, 1'b1});
    exp_mem.push_back('{32'h200, 32'h0, 1'b0});
    exp_rsp.push_back('{4'b0010, 32'h0, 1'b0});
    exp_rsp.push_back('{4'b1000, 32'hCAFEF00D, 1'b1});
    step();
    stbf = 1'b0; stbe = 1'b0; rwe = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_stbm(6, n);
      m = exp_mem.pop_front(); checks++;
      if (n != 1 || addrm !== m.addr || rwm !== m.rw || (m.rw && dtwm !== m.dtw)) begin
        failures++;
        $display("FAIL prio_req%0d: lat=%0d addrm=%h rwm=%b dtwm=%h, expected lat=1 addrm=%h rwm=%b dtwm=%h",
                 k, n, addrm, rwm, dtwm, m.addr, m.rw, m.dtw);
      end
      step();
      r = exp_rsp.pop_front();
      respond(1'b0, r.dat);
      checks++;
      if ({ackf, stlf, acke, stle} !== r.flags || (r.chk && r.flags[3] && dtrf !== r.dat)) begin
        failures++;
        $display("FAIL prio_rsp%0d: flags=%b dtrf=%h, expected flags=%b dtrf=%h", k, {ackf, stlf, acke, stle}, dtrf, r.flags, r.dat);
      end
    end
  endtask

  task automatic test_starvation();
    mreq_t m; rsp_t r; int n; int ne;
    ne = 0;
    for (int k = 0; k < 3; k++) begin
      exp_mem.push_back('{32'h1000 + 32'(4 * k), 32'h0, 1'b0});
      exp_rsp.push_back('{4'b0010, 32'hE000_0000 + 32'(k), 1'b1});
    end
    exp_mem.push_back('{32'h400, 32'h0, 1'b0});
    exp_rsp.push_back('{4'b1000, 32'hF000_0400, 1'b1});
    exp_mem.push_back('{32'h100C, 32'h0, 1'b0});
    exp_rsp.push_back('{4'b0010, 32'hE000_0003, 1'b1});
    addrf = 32'h400; stbf = 1'b1;
    addre = 32'h1000; rwe = 1'b0; stbe = 1'b1;
    step();
    stbf = 1'b0; addre = 32'h1004;
    for (int k = 0; k < 5; k++) begin
      wait_stbm(8, n);
      m = exp_mem.pop_front(); checks++;
      if (n != 1 || addrm !== m.addr || rwm !== m.rw) begin
        failures++;
        $display("FAIL starve_req%0d: lat=%0d addrm=%h rwm=%b, expected lat=1 addrm=%h rwm=%b", k, n, addrm, rwm, m.addr, m.rw);
      end
      r = exp_rsp.pop_front();
      respond(1'b0, r.dat);
      checks++;
      if ({ackf, stlf, acke, stle} !== r.flags || (r.flags[3] && dtrf !== r.dat) || (r.flags[1] && dtre !== r.dat)) begin
        failures++;
        $display("FAIL starve_rsp%0d: flags=%b dtrf=%h dtre=%h, expected flags=%b data=%h",
                 k, {ackf, stlf, acke, stle}, dtrf, dtre, r.flags, r.dat);
      end
      if (r.flags[1]) begin
        ne++;
        if (ne == 3) stbe = 1'b0;
        else         addre = 32'h1000 + 32'(4 * (ne + 1));
      end
    end
  endtask

  task automatic test_stall();
    mreq_t m; rsp_t r; int n;
    exp_mem.push_back('{32'h40, 32'h0, 1'b0});
    exp_rsp.push_back('{4'b0100, 32'h0, 1'b0});
    exp_mem.push_back('{32'h40, 32'h0, 1'b0});
    exp_rsp.push_back('{4'b1000, 32'h600DF00D, 1'b1});
    for (int k = 0; k < 2; k++) begin
      addrf = 32'h40; stbf = 1'b1;
      step();
      stbf = 1'b0;
      wait_stbm(6, n);
      m = exp_mem.pop_front(); checks++;
      if (n != 1 || addrm !== m.addr || rwm !== m.rw) begin
        failures++;
        $display("FAIL stall_req%0d: lat=%0d addrm=%h, expected lat=1 addrm=%h", k, n, addrm, m.addr);
      end
      r = exp_rsp.pop_front();
      respond(r.flags[2], r.dat);
      checks++;
      if ({ackf, stlf, acke, stle} !== r.flags || (r.chk && dtrf !== r.dat)) begin
        failures++;
        $display("FAIL stall_rsp%0d: flags=%b dtrf=%h, expected flags=%b dtrf=%h", k, {ackf, stlf, acke, stle}, dtrf, r.flags, r.dat);
      end
      step();
      checks++;
      if ({ackf, stlf, stbm} !== 3'b000) begin
        failures++;
        $display("FAIL stall_pulse%0d: ackf,stlf,stbm=%b, expected 000", k, {ackf, stlf, stbm});
      end
    end
  endtask

  task automatic test_flush();
    mreq_t m; rsp_t r; int n;
    exp_mem.push_back('{32'h80, 32'h0, 1'b0});
    exp_rsp.push_back('{4'b0000, 32'h0, 1'b0});
    exp_mem.push_back('{32'h2000, 32'h0, 1'b0});
    exp_rsp.push_back('{4'b0010, 32'h77, 1'b1});
    addrf = 32'h80; stbf = 1'b1;
    step();
    stbf = 1'b0;
    wait_stbm(6, n);
    m = exp_mem.pop_front(); checks++;
    if (n != 1 || addrm !== m.addr) begin
      failures++;
      $display("FAIL flush_req: lat=%0d addrm=%h, expected lat=1 addrm=%h", n, addrm, m.addr);
    end
    flushf = 1'b1;
    step();
    flushf = 1'b0;
    respond(1'b0, 32'hBAD0BAD0);
    r = exp_rsp.pop_front(); checks++;
    if ({ackf, stlf, acke, stle} !== r.flags) begin
      failures++;
      $display("FAIL flush_drop: flags=%b, expected flags=%b", {ackf, stlf, acke, stle}, r.flags);
    end
    addre = 32'h2000; rwe = 1'b0; stbe = 1'b1;
    step();
    stbe = 1'b0;
    wait_stbm(6, n);
    m = exp_mem.pop_front(); checks++;
    if (n != 1 || addrm !== m.addr || rwm !== m.rw) begin
      failures++;
      $display("FAIL flush_next_req: lat=%0d addrm=%h, expected lat=1 addrm=%h", n, addrm, m.addr);
    end
    r = exp_rsp.pop_front();
    respond(1'b0, r.dat);
    checks++;
    if ({ackf, stlf, acke, stle} !== r.flags || dtre !== r.dat) begin
      failures++;
      $display("FAIL flush_next_rsp: flags=%b dtre=%h, expected flags=%b dtre=%h", {ackf, stlf, acke, stle}, dtre, r.flags, r.dat);
    end
  endtask

  task automatic test_reset_mid();
    mreq_t m; int n;
    exp_mem.push_back('{32'h2400, 32'h0, 1'b0});
    addre = 32'h2400; rwe = 1'b0; stbe = 1'b1;
    step();
    stbe = 1'b0;
    wait_stbm(6, n);
    m = exp_mem.pop_front(); checks++;
    if (n != 1 || addrm !== m.addr) begin
      failures++;
      $display("FAIL midrst_req: lat=%0d addrm=%h, expected lat=1 addrm=%h", n, addrm, m.addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({stbm, acke, stle} !== 3'b000 || addrm !== 32'h0) begin
      failures++;
      $display("FAIL midrst_async: stbm,acke,stle=%b addrm=%h, expected 000 and 0", {stbm, acke, stle}, addrm);
    end
    step();
    reset = 1'b1;
    step();
    respond(1'b0, 32'h1);
    checks++;
    if ({ackf, stlf, acke, stle} !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_rsp: flags=%b, expected 0000", {ackf, stlf, acke, stle});
    end
    step();
    checks++;
    if (stbm !== 1'b0) begin
      failures++;
      $display("FAIL midrst_idle: stbm=%b, expected 0", stbm);
    end
  endtask

`ifdef HS32_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n; int cnt;
    cnt = -1;
    addre = 32'h5000; rwe = 1'b0; stbe = 1'b1;
    step();
    stbe = 1'b0;
    wait_stbm(6, n);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (stle === 1'b1) begin
        cnt = i;
        break;
      end
    end
    checks++;
    if (n != 1 || cnt != 8 || tmo !== 1'b1) begin
      failures++;
      $display("FAIL timeout_abort: lat=%0d stle_after=%0d tmo=%b, expected lat=1 stle_after=8 tmo=1", n, cnt, tmo);
    end
    step();
    respond(1'b0, 32'h9);
    checks++;
    if (acke !== 1'b0 || tmo !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: acke=%b tmo=%b, expected acke=0 tmo=1", acke, tmo);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (tmo !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: tmo=%b, expected 0", tmo);
    end
    step();
    reset = 1'b1;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_stall();
    test_flush();
    test_reset_mid();
`ifdef HS32_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
